// File: rtl/fmig2_pkg.sv
// rtl/fmig2_pkg.sv - shared width constant and cp index type for the fmig2 slice
// Purpose : default operand width and the encoding of the "which input won" index.
// Contents: FMIG2_BITS (default signed width), cp_idx_t (0 = x, 1 = y).
package fmig2_pkg;

  localparam int FMIG2_BITS = 8;

  typedef enum logic {
    CP_X = 1'b0,
    CP_Y = 1'b1
  } cp_idx_t;

endpackage

// File: rtl/fmig2_if.sv
// rtl/fmig2_if.sv - operand/result bundle for the fmig2 minimum unit
// Purpose : groups the input operands and the result of fmig2_unit.
// Signals : in_valid, x, y (driven by master); out_valid, min, cp (driven by slave).
// Modports: master = operand source / result sink, slave = the minimum unit.
interface fmig2_if #(
  parameter int BITS = fmig2_pkg::FMIG2_BITS
);

  logic                   in_valid;
  logic signed [BITS-1:0] x;
  logic signed [BITS-1:0] y;
  logic                   out_valid;
  logic signed [BITS-1:0] min;
  fmig2_pkg::cp_idx_t     cp;

  modport master (
    output in_valid, x, y,
    input  out_valid, min, cp
  );

  modport slave (
    input  in_valid, x, y,
    output out_valid, min, cp
  );

endinterface

// File: rtl/fmig2_cmp.sv
// rtl/fmig2_cmp.sv - combinational signed compare-and-select
// Purpose : min = smaller of x and y (signed), cp = index of the winner.
// Ports   : x, y (signed BITS operands), min (signed BITS), cp (0 = x, 1 = y).
module fmig2_cmp
  import fmig2_pkg::*;
#(
  parameter int BITS = FMIG2_BITS
) (
  input  logic signed [BITS-1:0] x,
  input  logic signed [BITS-1:0] y,
  output logic signed [BITS-1:0] min,
  output cp_idx_t                cp
);

  // Both operands are declared signed, so this is a full-width signed
  // compare; no subtraction is involved, so extremes cannot overflow.
  // A tie keeps x.
  always_comb begin
    min = x;
    cp  = CP_X;
    if (y < x) begin
      min = y;
      cp  = CP_Y;
    end
  end

endmodule

// File: rtl/fmig2_unit.sv
// rtl/fmig2_unit.sv - signed two-input minimum with optional output register
// Purpose : wraps fmig2_cmp; REG_OUT=1 registers min/cp/out_valid (1-cycle
//           latency, results held while idle), REG_OUT=0 is purely combinational.
// Ports   : clk, rst (async, active-high; unused when REG_OUT=0),
//           bus (fmig2_if.slave: in_valid, x, y -> out_valid, min, cp).
module fmig2_unit
  import fmig2_pkg::*;
#(
  parameter int BITS    = FMIG2_BITS,
  parameter int REG_OUT = 1
) (
  input logic   clk,
  input logic   rst,
  fmig2_if.slave bus
);

  logic signed [BITS-1:0] cmp_min;
  cp_idx_t                cmp_cp;

  fmig2_cmp #(
    .BITS (BITS)
  ) u_cmp (
    .x   (bus.x),
    .y   (bus.y),
    .min (cmp_min),
    .cp  (cmp_cp)
  );

  generate
    if (REG_OUT != 0) begin : g_reg
      logic signed [BITS-1:0] min_q;
      cp_idx_t                cp_q;
      logic                   valid_q;

      // Result registers only load on a valid input so min/cp hold across
      // idle cycles; reset clears everything, dropping any result in flight.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q <= 1'b0;
          min_q   <= '0;
          cp_q    <= CP_X;
        end else begin
          valid_q <= bus.in_valid;
          if (bus.in_valid) begin
            min_q <= cmp_min;
            cp_q  <= cmp_cp;
          end
        end
      end

      assign bus.out_valid = valid_q;
      assign bus.min       = min_q;
      assign bus.cp        = cp_q;
    end else begin : g_comb
      // clk and rst have no function in the combinational build.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;

      assign bus.out_valid = bus.in_valid;
      assign bus.min       = cmp_min;
      assign bus.cp        = cmp_cp;
    end
  endgenerate

endmodule

// File: tb/tb_fmig2_unit.sv
// tb/tb_fmig2_unit.sv - directed self-checking bench for fmig2_unit (registered and combinational)
module tb_fmig2_unit;
  import fmig2_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  fmig2_if #(.BITS(8)) bus1 ();
  fmig2_if #(.BITS(8)) bus0 ();

  fmig2_unit #(.BITS(8), .REG_OUT(1)) dut_reg (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  fmig2_unit #(.BITS(8), .REG_OUT(0)) dut_comb (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Back-to-back vector set with hand-computed minimum and index.
  logic signed [7:0] vx [5] = '{-8'sd1, -8'sd20, -8'sd30, -8'sd4, 8'sd5};
  logic signed [7:0] vy [5] = '{8'sd1, 8'sd2, -8'sd40, 8'sd40, 8'sd81};
  logic signed [7:0] vm [5] = '{-8'sd1, -8'sd20, -8'sd40, -8'sd4, 8'sd5};
  logic              vc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  task automatic drive1(input logic v, input logic signed [7:0] a, input logic signed [7:0] b);
    bus1.in_valid = v;
    bus1.x        = a;
    bus1.y        = b;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (bus1.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_valid: got %0b want 0", bus1.out_valid);
    end
    n_cmp++;
    if (bus1.min !== 8'sd0) begin
      n_bad++; $display("FAIL reset_min: got %0d want 0", bus1.min);
    end
    n_cmp++;
    if (bus1.cp !== 1'b0) begin
      n_bad++; $display("FAIL reset_cp: got %0b want 0", bus1.cp);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_cmp++;
        if (bus1.out_valid !== 1'b1) begin
          n_bad++; $display("FAIL b2b_valid[%0d]: got %0b want 1", i - 1, bus1.out_valid);
        end
        n_cmp++;
        if (bus1.min !== vm[i-1]) begin
          n_bad++; $display("FAIL b2b_min[%0d]: got %0d want %0d", i - 1, bus1.min, vm[i-1]);
        end
        n_cmp++;
        if (bus1.cp !== vc[i-1]) begin
          n_bad++; $display("FAIL b2b_cp[%0d]: got %0b want %0b", i - 1, bus1.cp, vc[i-1]);
        end
      end
      if (i < 5) drive1(1'b1, vx[i], vy[i]);
      else       drive1(1'b0, 8'sd0, 8'sd0);
    end
  endtask

  // Ties and extremes: each entry is x, y, expected min, expected cp.
  task automatic test_ties_extremes();
    logic signed [7:0] tx [4] = '{8'sd7, -8'sd128, 8'sd127, -8'sd128};
    logic signed [7:0] ty [4] = '{8'sd7, -8'sd128, -8'sd128, 8'sd127};
    logic signed [7:0] tm [4] = '{8'sd7, -8'sd128, -8'sd128, -8'sd128};
    logic              tc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive1(1'b1, tx[i], ty[i]);
      @(negedge clk);
      drive1(1'b0, 8'sd0, 8'sd0);
      n_cmp++;
      if (bus1.min !== tm[i]) begin
        n_bad++; $display("FAIL edge_min[%0d]: got %0d want %0d", i, bus1.min, tm[i]);
      end
      n_cmp++;
      if (bus1.cp !== tc[i]) begin
        n_bad++; $display("FAIL edge_cp[%0d]: got %0b want %0b", i, bus1.cp, tc[i]);
      end
    end
  endtask

  task automatic test_valid_idle_valid();
    @(negedge clk);
    drive1(1'b1, 8'sd10, 8'sd20);
    @(negedge clk);
    n_cmp++;
    if (bus1.out_valid !== 1'b1 || bus1.min !== 8'sd10 || bus1.cp !== 1'b0) begin
      n_bad++; $display("FAIL vin_first: got v=%0b min=%0d cp=%0b want v=1 min=10 cp=0", bus1.out_valid, bus1.min, bus1.cp);
    end
    drive1(1'b0, 8'sd99, -8'sd99);
    @(negedge clk);
    n_cmp++;
    if (bus1.out_valid !== 1'b0 || bus1.min !== 8'sd10 || bus1.cp !== 1'b0) begin
      n_bad++; $display("FAIL vin_idle_hold: got v=%0b min=%0d cp=%0b want v=0 min=10 cp=0", bus1.out_valid, bus1.min, bus1.cp);
    end
    drive1(1'b1, -8'sd5, -8'sd6);
    @(negedge clk);
    n_cmp++;
    if (bus1.out_valid !== 1'b1 || bus1.min !== -8'sd6 || bus1.cp !== 1'b1) begin
      n_bad++; $display("FAIL vin_second: got v=%0b min=%0d cp=%0b want v=1 min=-6 cp=1", bus1.out_valid, bus1.min, bus1.cp);
    end
    drive1(1'b0, 8'sd0, 8'sd0);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive1(1'b1, 8'sd50, 8'sd60);
    @(negedge clk);
    n_cmp++;
    if (bus1.out_valid !== 1'b1 || bus1.min !== 8'sd50) begin
      n_bad++; $display("FAIL arst_pre: got v=%0b min=%0d want v=1 min=50", bus1.out_valid, bus1.min);
    end
    drive1(1'b1, 8'sd9, 8'sd4);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus1.out_valid !== 1'b0 || bus1.min !== 8'sd0 || bus1.cp !== 1'b0) begin
      n_bad++; $display("FAIL arst_immediate: got v=%0b min=%0d cp=%0b want 0/0/0", bus1.out_valid, bus1.min, bus1.cp);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus1.out_valid !== 1'b0 || bus1.min !== 8'sd0 || bus1.cp !== 1'b0) begin
      n_bad++; $display("FAIL arst_ignore_inputs: got v=%0b min=%0d cp=%0b want 0/0/0", bus1.out_valid, bus1.min, bus1.cp);
    end
    @(negedge clk);
    rst = 1'b0;
    drive1(1'b0, 8'sd0, 8'sd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus1.out_valid !== 1'b0) begin
        n_bad++; $display("FAIL arst_idle[%0d]: got v=%0b want 0", i, bus1.out_valid);
      end
    end
    drive1(1'b1, 8'sd3, -8'sd2);
    @(negedge clk);
    drive1(1'b0, 8'sd0, 8'sd0);
    n_cmp++;
    if (bus1.out_valid !== 1'b1 || bus1.min !== -8'sd2 || bus1.cp !== 1'b1) begin
      n_bad++; $display("FAIL arst_first_result: got v=%0b min=%0d cp=%0b want v=1 min=-2 cp=1", bus1.out_valid, bus1.min, bus1.cp);
    end
  endtask

  task automatic test_comb();
    for (int i = 0; i < 5; i++) begin
      bus0.in_valid = 1'b1;
      bus0.x        = vx[i];
      bus0.y        = vy[i];
      #1;
      n_cmp++;
      if (bus0.out_valid !== 1'b1 || bus0.min !== vm[i] || bus0.cp !== vc[i]) begin
        n_bad++; $display("FAIL comb[%0d]: got v=%0b min=%0d cp=%0b want v=1 min=%0d cp=%0b", i, bus0.out_valid, bus0.min, bus0.cp, vm[i], vc[i]);
      end
    end
    bus0.in_valid = 1'b0;
    bus0.x        = 8'sd127;
    bus0.y        = -8'sd128;
    #1;
    n_cmp++;
    if (bus0.out_valid !== 1'b0 || bus0.min !== -8'sd128 || bus0.cp !== 1'b1) begin
      n_bad++; $display("FAIL comb_invalid: got v=%0b min=%0d cp=%0b want v=0 min=-128 cp=1", bus0.out_valid, bus0.min, bus0.cp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    drive1(1'b1, 8'sd33, -8'sd33);
    bus0.in_valid = 1'b0;
    bus0.x        = 8'sd0;
    bus0.y        = 8'sd0;
    test_reset();
    drive1(1'b0, 8'sd0, 8'sd0);
    test_back_to_back();
    test_ties_extremes();
    test_valid_idle_valid();
    test_async_reset();
    test_comb();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fmig2_unit.md
FMIG2_UNIT -- requirements
Module: fmig2_unit

Interface
REQ-001 Parameter BITS, default 8, signed two's-complement width of x, y and min; legal range is 2 to 32.
REQ-002 Parameter REG_OUT, default 1; 1 gives registered outputs, 0 gives combinational outputs.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  x and y are valid this cycle.
REQ-006 x  input  BITS  signed operand 0.
REQ-007 y  input  BITS  signed operand 1.
REQ-008 out_valid  output  1  min and cp are valid.
REQ-009 min  output  BITS  signed minimum of x and y.
REQ-010 cp  output  1  index of the minimum: 0 means x, 1 means y.

Function
REQ-011 Comparison SHALL be signed over the full BITS width, with no truncation, saturation or magnitude conversion.
REQ-012 If y < x (signed), the block SHALL produce min = y and cp = 1.
REQ-013 Otherwise, including the tie x == y, the block SHALL produce min = x and cp = 0.
REQ-014 REG_OUT = 1: a result for an in_valid = 1 input SHALL appear with exactly 1 cycle latency, and out_valid = 1 in that cycle.
REQ-015 REG_OUT = 1: on a cycle with in_valid = 0, out_valid SHALL drop to 0 on the next edge, and min and cp SHALL hold their last values.
REQ-016 REG_OUT = 1: back-to-back in_valid = 1 inputs SHALL give one result per cycle.
REQ-017 There is no backpressure and no stall input.
REQ-018 REG_OUT = 0: min and cp SHALL be pure combinational functions of x and y, out_valid SHALL equal in_valid, and clk and rst SHALL be unused.
REQ-019 Extreme values (-2^(BITS-1), 2^(BITS-1)-1) SHALL compare correctly, with no overflow in the comparison.

Reset
REQ-020 While rst = 1, out_valid = 0, min = 0 and cp = 0, taking effect immediately and independent of clk.
REQ-021 A result in flight when rst asserts SHALL be discarded.
REQ-022 After rst deasserts, the first result SHALL appear 1 cycle after the first sampled in_valid = 1.
REQ-023 Inputs sampled while rst = 1 SHALL be ignored.

Structure
REQ-024 Package fmig2_pkg SHALL hold the default width constant FMIG2_BITS = 8 and a typedef for the cp index; no other shared types.
REQ-025 The signed compare-and-select SHALL be one combinational sub-module, fmig2_cmp, with ports x, y, min, cp.
REQ-026 fmig2_unit SHALL wrap fmig2_cmp with the optional output register stage and the valid register, selected by a REG_OUT generate branch.

Verification
REQ-027 With BITS = 8 and REG_OUT = 1, back-to-back in_valid = 1 inputs (-1,1), (-20,2), (-30,-40), (-4,40), (5,81) SHALL give, one cycle later each, min/cp = -1/0, -20/0, -40/1, -4/0, 5/0.
REQ-028 Input (7,7) SHALL give min = 7, cp = 0, and input (-128,-128) SHALL give min = -128, cp = 0.
REQ-029 Inputs (127,-128) and (-128,127) SHALL give min/cp = -128/1 and -128/0 respectively.
REQ-030 Asserting rst asynchronously mid-stream, between clock edges, SHALL force out_valid, min and cp to 0 immediately.
REQ-031 After rst deasserts with in_valid low for 3 cycles, out_valid SHALL stay 0; a following input (3,-2) SHALL give min = -2, cp = 1 one cycle later.
REQ-032 A valid, idle, valid pattern SHALL show out_valid going 1, 0, 1, with min and cp held during the idle cycle.
REQ-033 With REG_OUT = 0, the REQ-027 vectors applied combinationally SHALL show the same results with zero latency.
REQ-034 With REG_OUT = 0, out_valid SHALL equal in_valid.
